// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_ADDR_W / IMEM_DEPTH / IMEM_DATA_W : instruction memory geometry
//   ld_state_t                             : loader FSM states
package imem_pkg;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;
  localparam int IMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CSUM,
    LD_DONE
  } ld_state_t;
endpackage

// File: rtl/imem_ld_counter.sv
// Loadable address / remaining-byte counter pair for the loader.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture base into addr and len into remaining
//   step       : addr += 1, remaining -= 1
//   base, len  : load values
//   addr       : current write address
//   last       : remaining == 1, i.e. the next step takes remaining to zero
module imem_ld_counter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W:0] remaining;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDR_W{1'b0}}, 1'b1});
endmodule

// File: rtl/imem_loader.sv
// Byte-stream writer for the instruction memory. Payload bytes arriving on a
// valid/ready stream are written sequentially from base_addr; one trailing
// checksum byte must bring the mod-256 sum of payload + checksum to zero.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : begin a load (only looked at in IDLE)
//   base_addr, length   : first byte address, payload byte count (1..DEPTH)
//   in_valid/in_data    : byte stream in
//   in_ready            : byte accepted this cycle when in_valid is high
//   mem_we/addr/wdata   : registered memory write port
//   busy, done          : load in progress, 1-cycle end-of-load pulse
//   err_range, err_csum : sticky error flags, cleared by an accepted start
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_csum
);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  ld_state_t         state, state_nxt;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] csum_chk;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              range_ok, accept, hs, load_hs;

  // length <= DEPTH is tested first, so base + length cannot overflow ADDR_W+1 bits.
  assign range_ok = (length != '0) && (length <= DEPTH_V) &&
                    (({1'b0, base_addr} + length) <= DEPTH_V);
  assign accept   = (state == LD_IDLE) && start && range_ok;
  assign hs       = in_valid && in_ready;
  assign load_hs  = hs && (state == LD_LOAD);
  assign csum_chk = csum + in_data;

  imem_ld_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (load_hs),
    .base  (base_addr),
    .len   (length),
    .addr  (addr),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      LD_IDLE: if (accept) state_nxt = LD_LOAD;
      LD_LOAD: begin
        in_ready = 1'b1;
        if (load_hs && last) state_nxt = LD_CSUM;
      end
      LD_CSUM: begin
        in_ready = 1'b1;
        if (hs) state_nxt = LD_DONE;
      end
      LD_DONE: state_nxt = LD_IDLE;
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Registered outputs: write port lags its handshake by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_range <= 1'b0;
      err_csum  <= 1'b0;
      csum      <= '0;
    end else begin
      mem_we <= load_hs;
      done   <= 1'b0;
      if (load_hs) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
        csum      <= csum_chk;
      end
      if (state == LD_IDLE && start) begin
        if (range_ok) begin
          csum      <= '0;
          err_range <= 1'b0;
          err_csum  <= 1'b0;
          busy      <= 1'b1;
        end else begin
          err_range <= 1'b1;
        end
      end
      if (state == LD_CSUM && hs) begin
        err_csum <= (csum_chk != '0);
        done     <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] base_addr = '0;
  logic [9:0] length = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_we, busy, done, err_range, err_csum;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [512];
  logic [8:0] wr_addr [64];
  logic [7:0] wr_data [64];
  int         wr_n = 0;
  logic [7:0] pay [8];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_range(err_range), .err_csum(err_csum)
  );

  always #5 clk = ~clk;

  // Write-port monitor: mirrors every write into a bench memory and a log.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  task automatic do_start(input logic [8:0] b, input logic [9:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends n payload bytes from pay[] then the checksum byte cs. gap inserts an
  // idle cycle after each valid cycle. restart_at pulses start while that byte is offered.
  task automatic run_stream(input int n, input logic [7:0] cs, input bit gap,
                            input int restart_at, input string name);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b0;
    bit acc;
    while (idx <= n && cyc < 200) begin
      in_valid = gap ? ~ph : 1'b1;
      ph = ~ph;
      in_data = (idx < n) ? pay[idx] : cs;
      start = (idx == restart_at);
      if (idx == restart_at) begin base_addr = 9'd100; length = 10'd3; end
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (idx <= n) begin
      errors++;
      $display("FAIL %s stream timeout: accepted %0d bytes, required %0d", name, idx, n + 1);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_range, err_csum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h busy=%b done=%b er=%b ec=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_range, err_csum);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load;
    pay[0] = 8'h8C; pay[1] = 8'h10; pay[2] = 8'h20; pay[3] = 8'h01;
    pay[4] = 8'h81; pay[5] = 8'hC3; pay[6] = 8'hE0; pay[7] = 8'h08;
    wr_n = 0;
    do_start(9'd0, 10'd8);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_busy got busy=%b rdy=%b, required 1 1", busy, in_ready);
    end
    // Payload sum is 0xE9, so 0x17 closes it to zero.
    run_stream(8, 8'h17, 1'b0, -1, "basic");
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_csum !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%b busy=%b ec=%b, required 1 0 0", done, busy, err_csum);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got done=%b rdy=%b, required 0 0", done, in_ready);
    end
    checks++;
    if (wr_n !== 8) begin errors++; $display("FAIL basic_wr_count got %0d required 8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== pay[i]) begin
        errors++;
        $display("FAIL basic_write%0d got %h:%h required %h:%h", i, wr_addr[i], wr_data[i], 9'(i), pay[i]);
      end
    end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h8C102001) begin
      errors++; $display("FAIL basic_word0 got %h required 8c102001", {mem[0], mem[1], mem[2], mem[3]});
    end
  endtask

  task automatic test_bad_csum;
    wr_n = 0;
    do_start(9'd0, 10'd8);
    run_stream(8, 8'h00, 1'b0, -1, "badcsum");
    checks++;
    if (done !== 1'b1 || err_csum !== 1'b1) begin
      errors++; $display("FAIL badcsum_flag got done=%b ec=%b, required 1 1", done, err_csum);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err_csum !== 1'b1) begin errors++; $display("FAIL badcsum_sticky got %b required 1", err_csum); end
    checks++;
    if (wr_n !== 8 || wr_addr[7] !== 9'd7 || wr_data[7] !== 8'h08) begin
      errors++; $display("FAIL badcsum_writes got n=%0d last=%h:%h required 8 007:08", wr_n, wr_addr[7], wr_data[7]);
    end
  endtask

  task automatic test_range;
    wr_n = 0;
    do_start(9'd508, 10'd8);
    checks++;
    if (err_range !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL range_reject got er=%b busy=%b rdy=%b, required 1 0 0", err_range, busy, in_ready);
    end
    checks++;
    if (err_csum !== 1'b1) begin errors++; $display("FAIL range_keeps_ecsum got %b required 1", err_csum); end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n !== 0) begin errors++; $display("FAIL range_no_write got %0d writes required 0", wr_n); end
    do_start(9'd0, 10'd1);
    checks++;
    if (err_range !== 1'b0 || err_csum !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL range_clear got er=%b ec=%b busy=%b, required 0 0 1", err_range, err_csum, busy);
    end
    pay[0] = 8'h55;
    run_stream(1, 8'hAB, 1'b0, -1, "len1");
    checks++;
    if (err_csum !== 1'b0 || wr_n !== 1 || wr_addr[0] !== 9'd0 || wr_data[0] !== 8'h55) begin
      errors++; $display("FAIL len1 got ec=%b n=%0d %h:%h required 0 1 000:55", err_csum, wr_n, wr_addr[0], wr_data[0]);
    end
    @(negedge clk);
    wr_n = 0;
    do_start(9'd0, 10'd0);
    checks++;
    if (err_range !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL range_len0 got er=%b busy=%b required 1 0", err_range, busy);
    end
    do_start(9'd1, 10'd512);
    checks++;
    if (err_range !== 1'b1 || busy !== 1'b0 || wr_n !== 0) begin
      errors++; $display("FAIL range_over got er=%b busy=%b n=%0d required 1 0 0", err_range, busy, wr_n);
    end
  endtask

  task automatic test_gapped_top;
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'h11 * (i + 1));
    wr_n = 0;
    do_start(9'd504, 10'd8);
    // Payload sum 0x264 -> 0x64; checksum 0x9C.
    run_stream(8, 8'h9C, 1'b1, -1, "gapped");
    checks++;
    if (done !== 1'b1 || err_csum !== 1'b0 || err_range !== 1'b0) begin
      errors++; $display("FAIL gapped_done got done=%b ec=%b er=%b required 1 0 0", done, err_csum, err_range);
    end
    checks++;
    if (wr_n !== 8) begin errors++; $display("FAIL gapped_wr_count got %0d required 8", wr_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[i] !== 9'(504 + i) || wr_data[i] !== pay[i]) begin
        errors++;
        $display("FAIL gapped_write%0d got %h:%h required %h:%h", i, wr_addr[i], wr_data[i], 9'(504 + i), pay[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    wr_n = 0;
    do_start(9'd0, 10'd8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = pay[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || busy !== 1'b1 || wr_n !== 3) begin
      errors++; $display("FAIL abort_pre got we=%b busy=%b n=%0d required 1 1 3", mem_we, busy, wr_n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_async got we=%b busy=%b rdy=%b required 0 0 0", mem_we, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    wr_n = 0;
    do_start(9'd0, 10'd4);
    // Payload sum 0x338 -> 0x38; checksum 0xC8.
    run_stream(4, 8'hC8, 1'b0, -1, "after_abort");
    checks++;
    if (done !== 1'b1 || err_csum !== 1'b0 || wr_n !== 4) begin
      errors++; $display("FAIL after_abort got done=%b ec=%b n=%0d required 1 0 4", done, err_csum, wr_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== pay[i]) begin
        errors++;
        $display("FAIL after_abort_write%0d got %h:%h required %h:%h", i, wr_addr[i], wr_data[i], 9'(i), pay[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    wr_n = 0;
    do_start(9'd16, 10'd4);
    run_stream(4, 8'hF6, 1'b0, 1, "restart");
    checks++;
    if (done !== 1'b1 || err_csum !== 1'b0 || err_range !== 1'b0 || wr_n !== 4) begin
      errors++; $display("FAIL restart_done got done=%b ec=%b er=%b n=%0d required 1 0 0 4",
                         done, err_csum, err_range, wr_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 9'(16 + i) || wr_data[i] !== pay[i]) begin
        errors++;
        $display("FAIL restart_write%0d got %h:%h required %h:%h", i, wr_addr[i], wr_data[i], 9'(16 + i), pay[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_n !== 4) begin
      errors++; $display("FAIL restart_idle got busy=%b n=%0d required 0 4", busy, wr_n);
    end
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_bad_csum;
    test_range;
    test_gapped_top;
    test_reset_mid_load;
    test_start_while_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
